timer_cfg_seq: RTL

- APB master sequencer that programs one timer_top instance from a single start pulse.
- Issues the full bring-up sequence: stop, reload TDR0/TDR1, compare TCMP0/TCMP1, TIER, divider setup with timer off, start.
- Reads TCR back after the start write and checks it against the expected value.
- Sits between the system control logic and the timer's APB slave port.

---
 rtl/timer_cfg_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/timer_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : timer_cfg_seq
// Brief    : APB master that runs the timer bring-up write sequence from one
//            start pulse, then reads TCR back and checks it.
// Revision : 1.0 - initial release
// ============================================================================
module timer_cfg_seq #(
    parameter int TIMEOUT      = 16,
    parameter bit ABORT_ON_ERR = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [63:0] cfg_reload,
    input  logic [63:0] cfg_cmp,
    input  logic [3:0]  cfg_div_val,
    input  logic        cfg_div_en,
    input  logic        cfg_int_en,
    output logic        tim_psel,
    output logic        tim_penable,
    output logic        tim_pwrite,
    output logic [11:0] tim_paddr,
    output logic [31:0] tim_pwdata,
    output logic [3:0]  tim_pstrb,
    input  logic        tim_pready,
    input  logic        tim_pslverr,
    input  logic [31:0] tim_prdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  err_step
);

    localparam int              CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_to_last   = CW'(TIMEOUT - 1);
    localparam logic [1:0]      c_st_idle   = 2'd0;
    localparam logic [1:0]      c_st_setup  = 2'd1;
    localparam logic [1:0]      c_st_access = 2'd2;
    localparam logic [3:0]      c_last_step = 4'd8;

    logic [1:0]    r_state;
    logic [3:0]    r_step;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_reload;
    logic [63:0]   r_cmp;
    logic [3:0]    r_div_val;
    logic          r_div_en;
    logic          r_int_en;

    logic [3:0]    w_nstep;
    logic [11:0]   w_naddr;
    logic [31:0]   w_ndata;
    logic          w_nwrite;
    logic [3:0]    w_nstrb;
    logic [31:0]   w_tcr_off;
    logic [31:0]   w_rb_exp;
    logic          w_xfer_done;
    logic          w_xfer_err;
    logic          w_timeout;
    logic          w_err_evt;
    logic          w_finish;

    assign w_tcr_off = {20'b0, r_div_val, 6'b0, r_div_en, 1'b0};
    assign w_rb_exp  = w_tcr_off | 32'h1;
    assign w_nstep   = r_step + 4'd1;

    // Address/data of the transfer that follows the current one.
    always_comb begin
        w_naddr  = 12'h000;
        w_ndata  = 32'h0;
        w_nwrite = 1'b1;
        w_nstrb  = 4'hF;
        case (w_nstep)
            4'd1:    begin w_naddr = 12'h004; w_ndata = r_reload[31:0];  end
            4'd2:    begin w_naddr = 12'h008; w_ndata = r_reload[63:32]; end
            4'd3:    begin w_naddr = 12'h00C; w_ndata = r_cmp[31:0];     end
            4'd4:    begin w_naddr = 12'h010; w_ndata = r_cmp[63:32];    end
            4'd5:    begin w_naddr = 12'h014; w_ndata = {31'b0, r_int_en}; end
            4'd6:    w_ndata = w_tcr_off;
            4'd7:    w_ndata = w_rb_exp;
            4'd8:    begin w_nwrite = 1'b0; w_nstrb = 4'h0; end
            default: ;
        endcase
    end

    assign w_xfer_done = (r_state == c_st_access) && tim_pready;
    assign w_xfer_err  = tim_pslverr || ((r_step == c_last_step) && (tim_prdata != w_rb_exp));
    // pready on the final timeout cycle still completes the transfer.
    assign w_timeout   = (r_state == c_st_access) && !tim_pready && (r_cnt == c_to_last);
    assign w_err_evt   = (w_xfer_done && w_xfer_err) || w_timeout;
    assign w_finish    = w_timeout ||
                         (w_xfer_done && ((r_step == c_last_step) || (tim_pslverr && ABORT_ON_ERR)));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= c_st_idle;
            r_step      <= 4'd0;
            r_cnt       <= '0;
            r_reload    <= 64'h0;
            r_cmp       <= 64'h0;
            r_div_val   <= 4'h0;
            r_div_en    <= 1'b0;
            r_int_en    <= 1'b0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= 12'h000;
            tim_pwdata  <= 32'h0;
            tim_pstrb   <= 4'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_step    <= 4'd0;
        end else begin
            done <= 1'b0;
            if (w_err_evt) begin
                err <= 1'b1;
                if (!err) begin
                    err_step <= r_step;
                end
            end
            if (w_finish) begin
                r_state     <= c_st_idle;
                r_step      <= 4'd0;
                tim_psel    <= 1'b0;
                tim_penable <= 1'b0;
                tim_pwrite  <= 1'b0;
                tim_paddr   <= 12'h000;
                tim_pwdata  <= 32'h0;
                tim_pstrb   <= 4'h0;
                busy        <= 1'b0;
                done        <= 1'b1;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (cfg_start) begin
                            r_reload    <= cfg_reload;
                            r_cmp       <= cfg_cmp;
                            r_div_val   <= cfg_div_val;
                            r_div_en    <= cfg_div_en;
                            r_int_en    <= cfg_int_en;
                            err         <= 1'b0;
                            err_step    <= 4'd0;
                            r_step      <= 4'd0;
                            tim_psel    <= 1'b1;
                            tim_penable <= 1'b0;
                            tim_pwrite  <= 1'b1;
                            tim_paddr   <= 12'h000;
                            tim_pwdata  <= 32'h0;
                            tim_pstrb   <= 4'hF;
                            busy        <= 1'b1;
                            r_state     <= c_st_setup;
                        end
                    end
                    c_st_setup: begin
                        tim_penable <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_st_access;
                    end
                    c_st_access: begin
                        if (w_xfer_done) begin
                            r_step      <= w_nstep;
                            tim_penable <= 1'b0;
                            tim_pwrite  <= w_nwrite;
                            tim_paddr   <= w_naddr;
                            tim_pwdata  <= w_ndata;
                            tim_pstrb   <= w_nstrb;
                            r_state     <= c_st_setup;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
